// File: rtl/hssi_csr_avmm_initiator.sv
// -----------------------------------------------------------------------------
// hssi_csr_avmm_initiator
//
// Avalon-MM initiator for the HSSI traffic-controller CSR slave. It takes one
// command at a time on a valid/ready command port. It runs a single AVMM read
// or write to the selected Ethernet port and honours waitrequest. It then
// returns read data and an error code on a valid/ready response port.
//
// Optional feature macro: HSSI_CSR_INIT_TIMEOUT_EN
//   When defined, a transfer whose waitrequest stays high for TIMEOUT_CYCLES
//   cycles is abandoned and answered with error 2 and all-ones read data.
//   When undefined, a transfer waits on waitrequest indefinitely.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   i_cmd_*/o_cmd_ready   command: valid, write(1)/read(0), port, addr, wdata
//   o_rsp_*/i_rsp_ready   response: valid, rdata (0 for writes), error
//                         (0 ok, 1 bad port, 2 timeout)
//   o_avmm_*, i_avmm_*    registered Avalon-MM initiator interface
//   o_csr_port_sel        port select, stable for the whole transfer
//   o_err_count           saturating count of errored commands
// -----------------------------------------------------------------------------
module hssi_csr_avmm_initiator #(
  parameter int NUM_ETH        = 1,
  parameter int AVMM_DATA_W    = 32,
  parameter int AVMM_ADDR_W    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_cmd_write,
  input  logic [3:0]             i_cmd_port,
  input  logic [AVMM_ADDR_W-1:0] i_cmd_addr,
  input  logic [AVMM_DATA_W-1:0] i_cmd_wdata,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [AVMM_DATA_W-1:0] o_rsp_rdata,
  output logic [1:0]             o_rsp_error,
  output logic [AVMM_ADDR_W-1:0] o_avmm_addr,
  output logic                   o_avmm_read,
  output logic                   o_avmm_write,
  output logic [AVMM_DATA_W-1:0] o_avmm_writedata,
  input  logic [AVMM_DATA_W-1:0] i_avmm_readdata,
  input  logic                   i_avmm_waitrequest,
  output logic [3:0]             o_csr_port_sel,
  output logic [15:0]            o_err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_PORT    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Port indices are compared one bit wider so NUM_ETH = 16 is representable.
  localparam logic [4:0] NUM_ETH_W = 5'(NUM_ETH);

  if (NUM_ETH < 1 || NUM_ETH > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("hssi_csr_avmm_initiator: illegal NUM_ETH or TIMEOUT_CYCLES");
  end

  state_t state_r;
  logic   cmd_fire_s;
  logic   port_bad_s;
  logic   timeout_s;

  // Saturating increment for the error counter; it sticks at all ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Decode command acceptance and port legality.
  always_comb begin
    cmd_fire_s = (state_r == ST_IDLE) && i_cmd_valid && o_cmd_ready;
    port_bad_s = ({1'b0, i_cmd_port} >= NUM_ETH_W);
  end

`ifdef HSSI_CSR_INIT_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;

  // Stalled-cycle counter: cleared on entry to ACCESS, counts waitrequest cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (cmd_fire_s) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && i_avmm_waitrequest) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Timeout fires only while still stalled, so a completion in the same cycle wins.
  always_comb begin
    if ((state_r == ST_ACCESS) && i_avmm_waitrequest && (to_cnt_r == TO_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end
`else
  // Without the timeout feature a stalled transfer never aborts.
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      o_cmd_ready      <= 1'b1;
      o_rsp_valid      <= 1'b0;
      o_rsp_rdata      <= {AVMM_DATA_W{1'b0}};
      o_rsp_error      <= ERR_OK;
      o_avmm_addr      <= {AVMM_ADDR_W{1'b0}};
      o_avmm_read      <= 1'b0;
      o_avmm_write     <= 1'b0;
      o_avmm_writedata <= {AVMM_DATA_W{1'b0}};
      o_csr_port_sel   <= 4'd0;
      o_err_count      <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_fire_s) begin
            o_cmd_ready      <= 1'b0;
            o_avmm_addr      <= i_cmd_addr;
            o_avmm_writedata <= i_cmd_wdata;
            o_csr_port_sel   <= i_cmd_port;
            if (port_bad_s) begin
              // Unreachable port: answer directly, never touch the bus.
              state_r     <= ST_RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= {AVMM_DATA_W{1'b0}};
              o_rsp_error <= ERR_PORT;
              o_err_count <= sat_inc(o_err_count);
            end else begin
              state_r      <= ST_ACCESS;
              o_avmm_read  <= ~i_cmd_write;
              o_avmm_write <= i_cmd_write;
            end
          end
        end
        ST_ACCESS: begin
          if (!i_avmm_waitrequest) begin
            state_r      <= ST_RESP;
            o_avmm_read  <= 1'b0;
            o_avmm_write <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_error  <= ERR_OK;
            o_rsp_rdata  <= o_avmm_read ? i_avmm_readdata : {AVMM_DATA_W{1'b0}};
          end else if (timeout_s) begin
            state_r      <= ST_RESP;
            o_avmm_read  <= 1'b0;
            o_avmm_write <= 1'b0;
            o_rsp_valid  <= 1'b1;
            o_rsp_error  <= ERR_TIMEOUT;
            o_rsp_rdata  <= {AVMM_DATA_W{1'b1}};
            o_err_count  <= sat_inc(o_err_count);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            state_r     <= ST_IDLE;
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          o_cmd_ready  <= 1'b1;
          o_rsp_valid  <= 1'b0;
          o_avmm_read  <= 1'b0;
          o_avmm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hssi_csr_avmm_initiator.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hssi_csr_avmm_initiator (NUM_ETH = 4, timeout 8).
// A driver issues directed and random commands and pushes the expected
// response and bus transfer into queues. An AVMM slave model and a response
// monitor pop those queues and compare. Honours HSSI_CSR_INIT_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hssi_csr_avmm_initiator;

  localparam int NUM_ETH = 4;
  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int TO      = 8;
`ifdef HSSI_CSR_INIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    err;
    logic [15:0]   errcnt;
    int            first_cyc;
  } rsp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    port;
    int            w;
    logic [DW-1:0] rd;
    int            dur;
  } req_t;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          cmd_valid  = 1'b0;
  logic          cmd_write  = 1'b0;
  logic [3:0]    cmd_port   = 4'd0;
  logic [AW-1:0] cmd_addr   = '0;
  logic [DW-1:0] cmd_wdata  = '0;
  logic          rsp_ready  = 1'b0;
  logic [DW-1:0] avmm_rdata = '0;
  logic          avmm_wait  = 1'b1;

  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_error;
  logic [AW-1:0] avmm_addr;
  logic          avmm_read;
  logic          avmm_write;
  logic [DW-1:0] avmm_wdata;
  logic [3:0]    port_sel;
  logic [15:0]   err_count;

  int          n_chk      = 0;
  int          n_pass     = 0;
  int          cyc        = 0;
  int          issued     = 0;
  int          completed  = 0;
  int          last_first = 0;
  int          k          = 0;
  logic [15:0] exp_err    = 16'd0;
  logic [3:0]  last_port  = 4'd0;
  bit          bp_hold    = 1'b0;
  bit          seen       = 1'b0;
  bit          hs_pending = 1'b0;

  rsp_t rsp_q[$];
  req_t req_q[$];

  hssi_csr_avmm_initiator #(
    .NUM_ETH(NUM_ETH), .AVMM_DATA_W(DW), .AVMM_ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_port(cmd_port), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_error(rsp_error), .o_avmm_addr(avmm_addr), .o_avmm_read(avmm_read),
    .o_avmm_write(avmm_write), .o_avmm_writedata(avmm_wdata),
    .i_avmm_readdata(avmm_rdata), .i_avmm_waitrequest(avmm_wait),
    .o_csr_port_sel(port_sel), .o_err_count(err_count)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // AVMM slave model: programmable wait states, checks every request cycle.
  always @(negedge clk) begin
    req_t cur;
    if (reset) begin
      req_q.delete();
      k = 0;
      avmm_wait = 1'b1;
    end else begin
      chk("port_sel_hold", port_sel, last_port);
      if (avmm_read || avmm_write) begin
        if (req_q.size() == 0) begin
          chk("spurious_avmm_req", {avmm_read, avmm_write}, 2'b00);
          avmm_wait = 1'b0;
        end else begin
          cur = req_q[0];
          k++;
          chk("avmm_read", avmm_read, !cur.wr);
          chk("avmm_write", avmm_write, cur.wr);
          chk("avmm_addr", avmm_addr, cur.addr);
          chk("avmm_port_sel", port_sel, cur.port);
          if (cur.wr) chk("avmm_writedata", avmm_wdata, cur.wdata);
          if (k <= cur.w) begin
            avmm_wait  = 1'b1;
            avmm_rdata = $urandom;
          end else begin
            avmm_wait  = 1'b0;
            avmm_rdata = cur.rd;
          end
          if (k == cur.dur) begin
            void'(req_q.pop_front());
            k = 0;
          end
        end
      end else begin
        if (k != 0) begin
          chk("avmm_req_held", avmm_read | avmm_write, 1'b1);
          void'(req_q.pop_front());
          k = 0;
        end
        avmm_wait  = 1'($urandom_range(0, 1));
        avmm_rdata = $urandom;
      end
    end
  end

  // Response monitor: compares the head of the scoreboard while valid is high.
  always @(negedge clk) begin
    rsp_t cur;
    if (reset) begin
      rsp_q.delete();
      seen = 1'b0;
      hs_pending = 1'b0;
      rsp_ready = 1'b0;
    end else begin
      if (hs_pending) begin
        completed++;
        hs_pending = 1'b0;
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("spurious_rsp", rsp_valid, 1'b0);
          rsp_ready = 1'b1;
        end else begin
          cur = rsp_q[0];
          if (!seen) chk("rsp_latency", cyc, cur.first_cyc);
          seen = 1'b1;
          chk("rsp_rdata", rsp_rdata, cur.rdata);
          chk("rsp_error", rsp_error, cur.err);
          chk("err_count", err_count, cur.errcnt);
          rsp_ready = bp_hold ? 1'b0 : 1'($urandom_range(0, 1));
          if (rsp_ready) begin
            void'(rsp_q.pop_front());
            seen = 1'b0;
            hs_pending = 1'b1;
          end
        end
      end else begin
        if (seen) begin
          chk("rsp_valid_held", rsp_valid, 1'b1);
          void'(rsp_q.pop_front());
          seen = 1'b0;
          completed++;
        end
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Advance to the next drive slot and check command readiness.
  task automatic step();
    @(negedge clk);
    #1;
    if (!reset) chk("cmd_ready", cmd_ready, (issued == completed));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_error"}, rsp_error, 2'd0);
    chk({tag, "_avmm_addr"}, avmm_addr, 16'h0);
    chk({tag, "_avmm_read"}, avmm_read, 1'b0);
    chk({tag, "_avmm_write"}, avmm_write, 1'b0);
    chk({tag, "_avmm_wdata"}, avmm_wdata, 32'h0);
    chk({tag, "_port_sel"}, port_sel, 4'd0);
    chk({tag, "_err_count"}, err_count, 16'd0);
  endtask

  // Issue one command; the expected outcome comes from the command rules.
  task automatic send(input logic wr, input logic [3:0] port, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int w, input logic [DW-1:0] rd);
    rsp_t er;
    req_t eq;
    int   guard;
    int   dur;
    bit   bad;
    bit   tmo;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_port  = port;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready && guard < 400) begin
      step();
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    bad = (int'(port) >= NUM_ETH);
    tmo = !bad && TO_EN && (w >= TO);
    dur = tmo ? TO : w + 1;
    er.err   = bad ? 2'd1 : (tmo ? 2'd2 : 2'd0);
    er.rdata = (bad || (wr && !tmo)) ? 32'h0 : (tmo ? 32'hFFFF_FFFF : rd);
    if (er.err != 2'd0 && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    er.errcnt    = exp_err;
    er.first_cyc = cyc + 1 + (bad ? 0 : dur);
    rsp_q.push_back(er);
    if (!bad) begin
      eq.wr = wr; eq.addr = addr; eq.wdata = wdata; eq.port = port;
      eq.w = w; eq.rd = rd; eq.dur = dur;
      req_q.push_back(eq);
    end
    issued++;
    last_port  = port;
    last_first = er.first_cyc;
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_port  = 4'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic random_cmds(input int n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] p;
      p = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      send(1'($urandom_range(0, 1)), p, AW'($urandom), $urandom,
           TO_EN ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 5)), $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("por");
    reset = 1'b0;
    step();

    send(1'b1, 4'd0, 16'h0010, 32'hA5A5_5A5A, 0, 32'h0);
    send(1'b0, 4'd2, 16'h0004, 32'h0, 5, 32'h1234_5678);
    send(1'b0, 4'd5, 16'h0008, 32'h0, 0, 32'h0);
`ifdef HSSI_CSR_INIT_TIMEOUT_EN
    send(1'b0, 4'd1, 16'h0020, 32'h0, 1000, 32'h0BAD_0BAD);
    send(1'b0, 4'd1, 16'h0024, 32'h0, TO - 1, 32'h1111_2222);
    send(1'b1, 4'd3, 16'h0028, 32'h3333_4444, TO, 32'h0);
    send(1'b0, 4'd2, 16'h002C, 32'h0, 1, 32'h5555_6666);
`endif

    // Ten-plus cycles of response backpressure, then an immediate follow-up.
    bp_hold = 1'b1;
    send(1'b0, 4'd3, 16'h0100, 32'h0, 2, 32'hCAFE_0001);
    while (cyc < last_first + 10) step();
    bp_hold = 1'b0;
    send(1'b1, 4'd1, 16'h0104, 32'hBEEF_0002, 0, 32'h0);

    random_cmds(150);

    // Reset in the middle of a stalled read: the command must vanish.
    send(1'b0, 4'd1, 16'h0040, 32'h0, 6, 32'hDEAD_BEEF);
    step();
    step();
    reset = 1'b1;
    #1;
    chk_reset_outs("mid_access_reset");
    repeat (2) step();
    issued    = completed;
    exp_err   = 16'd0;
    last_port = 4'd0;
    reset = 1'b0;
    repeat (10) step();
    chk_reset_outs("after_abort");

    random_cmds(40);

    guard = 0;
    while (issued != completed && guard < 500) begin
      step();
      guard++;
    end
    chk("drain_responses", completed, issued);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
